mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, width of every address and data bus.
REQ-002 Parameter STARVE_LIMIT, default 4, number of consecutive contended data grants after which fetch wins.
REQ-003 Parameter TIMEOUT, default 255, number of busy cycles without MemAck before abort.
REQ-004 Clock  in  1  the single clock; all state changes on its rising edge.
REQ-005 Resetn  in  1  reset; asynchronous and active-low.
REQ-006 InstrReq  in  1  fetch requester wants a read.
REQ-007 InstrAddr  in  WORD_SIZE  fetch address.
REQ-008 InstrGrant  out  1  one-cycle pulse: the fetch request is accepted this cycle.
REQ-009 InstrDone  out  1  one-cycle pulse: InstrRdata is valid.
REQ-010 InstrRdata  out  WORD_SIZE  fetch read data.
REQ-011 DataReq, DataWe  in  1 each  data requester wants an access; DataWe=1 selects a write.
REQ-012 DataAddr, DataWdata  in  WORD_SIZE each  data address and write data.
REQ-013 DataGrant, DataDone  out  1 each  same meaning as the fetch pair.
REQ-014 DataRdata  out  WORD_SIZE  load data; 0 after a write.
REQ-015 MemReq, MemWe  out  1 each  memory request and write enable toward the shared port.
REQ-016 MemAddr, MemWdata  out  WORD_SIZE each  latched address and write data.
REQ-017 MemRdata  in  WORD_SIZE; MemAck  in  1  memory completion, valid the same cycle.
REQ-018 Err  out  1  pulses with the Done pulse of a timed-out transaction.

Function
REQ-019 FSM states: IDLE, BUSY_I, BUSY_D.
REQ-020 IDLE with only one request: that requester SHALL be granted combinationally in that cycle, and its address, write enable and write data SHALL be latched at the clock edge; the next state SHALL be BUSY_I or BUSY_D respectively.
REQ-021 IDLE with both requests: data wins unless starve_cnt==STARVE_LIMIT, in which case fetch wins.
REQ-022 starve_cnt: +1 on each contended data grant (saturating at STARVE_LIMIT); cleared on any fetch grant, and cleared in any cycle where InstrReq=0.
REQ-023 In BUSY_x, MemReq=1 and MemAddr/MemWe/MemWdata SHALL hold the latched values; no grant SHALL issue.
REQ-024 MemAck=1 in BUSY_x: register MemRdata (0 for a write), pulse xDone on the next cycle, and return to IDLE.
REQ-025 The cycle carrying xDone is IDLE, and a new grant may issue in it, giving back-to-back issue every 2 cycles with zero-wait memory.
REQ-026 Latency from Grant to Done SHALL be (ack wait cycles + 2).
REQ-027 busy_cnt: cleared on grant, +1 each BUSY cycle; at busy_cnt==TIMEOUT without MemAck, drop MemReq, pulse xDone and Err with Rdata=0, and return to IDLE.
REQ-028 MemAck in the timeout cycle SHALL win: a normal completion with Err=0.
REQ-029 MemAck while IDLE SHALL be ignored.
REQ-030 A requester SHALL hold Req and its address until it sees Grant; a Req drop before Grant SHALL be permitted.
REQ-031 Outputs other than the combinational Grants SHALL be registered; only one of InstrDone/DataDone SHALL be high per cycle.

Reset
REQ-032 Resetn low SHALL force: state=IDLE, starve_cnt=0, busy_cnt=0, all Grant/Done/Err/MemReq/MemWe=0, and all data/address outputs=0.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no Done pulse; after release, a late MemAck SHALL be ignored.

Structure
REQ-034 WORD_SIZE and the arbiter state enum SHALL live in the shared processor package.
REQ-035 One sub-module is natural: arb_counter, a saturating counter with clear and enable, instantiated for starve_cnt and busy_cnt.

Verification
REQ-036 Single fetch: InstrReq, InstrAddr=0x0010, MemAck on the first busy cycle with MemRdata=0xBEEF -> InstrDone 2 cycles after grant, InstrRdata=0xBEEF.
REQ-037 Contention: both Req held, STARVE_LIMIT=4, zero-wait memory -> grants in the order D, D, D, D, I, D, D, D, D, I.
REQ-038 Write: DataWe=1, DataAddr=0x0100, DataWdata=0x1234, MemAck after 3 cycles -> MemWe=1 and MemAddr/MemWdata stable for 3 cycles, DataDone=1, DataRdata=0.
REQ-039 Timeout: TIMEOUT=8, no MemAck -> MemReq drops after 8 busy cycles; DataDone=1, Err=1, DataRdata=0.
REQ-040 Ack and timeout in the same cycle -> normal completion with Err=0 and the captured data.
REQ-041 Resetn low in BUSY_D, then MemAck pulsed after release -> no Done pulse, state IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared processor package: word size, arbiter state encoding and a
// counter-width helper used by the memory arbiter.
package mem_arbiter_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module arb_counter #(
  parameter int MAX   = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  // Count enabled cycles, holding at MAX; clear restarts from zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != WIDTH'(MAX))) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single memory port.
// Grants are combinational in IDLE; everything else is registered.
module mem_arbiter #(
  parameter int WORD_SIZE    = mem_arbiter_pkg::WORD_SIZE,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 InstrReq,
  input  logic [WORD_SIZE-1:0] InstrAddr,
  output logic                 InstrGrant,
  output logic                 InstrDone,
  output logic [WORD_SIZE-1:0] InstrRdata,
  input  logic                 DataReq,
  input  logic                 DataWe,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataWdata,
  output logic                 DataGrant,
  output logic                 DataDone,
  output logic [WORD_SIZE-1:0] DataRdata,
  output logic                 MemReq,
  output logic                 MemWe,
  output logic [WORD_SIZE-1:0] MemAddr,
  output logic [WORD_SIZE-1:0] MemWdata,
  input  logic [WORD_SIZE-1:0] MemRdata,
  input  logic                 MemAck,
  output logic                 Err
);

  import mem_arbiter_pkg::*;

  localparam int SW = cnt_width(STARVE_LIMIT);
  localparam int BW = cnt_width(TIMEOUT);

  arb_state_t    state;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] busy_cnt;
  logic          idle;
  logic          fetch_wins;
  logic          busy;
  logic          busy_last;

  // NOTE: grants are combinational, so they are gated with Resetn to stay low during reset.
  assign idle       = (state == IDLE) && Resetn;
  assign fetch_wins = (starve_cnt == SW'(STARVE_LIMIT));
  assign InstrGrant = idle && InstrReq && (!DataReq || fetch_wins);
  assign DataGrant  = idle && DataReq && !(InstrReq && fetch_wins);
  assign busy       = (state == BUSY_I) || (state == BUSY_D);
  // busy_cnt is zero in the first busy cycle, so this marks the TIMEOUT-th busy cycle.
  assign busy_last  = (busy_cnt == BW'(TIMEOUT - 1));

  // Consecutive contended data wins; reset whenever fetch is served or stops asking.
  arb_counter #(.MAX(STARVE_LIMIT), .WIDTH(SW)) u_starve_cnt (
    .clk   (Clock),
    .rst_n (Resetn),
    .clr   (InstrGrant || !InstrReq),
    .en    (DataGrant && InstrReq),
    .cnt   (starve_cnt)
  );

  // Busy cycles of the current transaction, restarted by every grant.
  arb_counter #(.MAX(TIMEOUT), .WIDTH(BW)) u_busy_cnt (
    .clk   (Clock),
    .rst_n (Resetn),
    .clr   (InstrGrant || DataGrant),
    .en    (busy),
    .cnt   (busy_cnt)
  );

  // Arbiter FSM with registered memory-port, done, error and read-data outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      MemReq     <= 1'b0;
      MemWe      <= 1'b0;
      MemAddr    <= '0;
      MemWdata   <= '0;
      InstrDone  <= 1'b0;
      DataDone   <= 1'b0;
      InstrRdata <= '0;
      DataRdata  <= '0;
      Err        <= 1'b0;
    end else begin
      InstrDone <= 1'b0;
      DataDone  <= 1'b0;
      Err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (InstrGrant) begin
            state    <= BUSY_I;
            MemReq   <= 1'b1;
            MemWe    <= 1'b0;
            MemAddr  <= InstrAddr;
            MemWdata <= '0;
          end else if (DataGrant) begin
            state    <= BUSY_D;
            MemReq   <= 1'b1;
            MemWe    <= DataWe;
            MemAddr  <= DataAddr;
            MemWdata <= DataWdata;
          end
        end
        BUSY_I, BUSY_D: begin
          // An ack in the last allowed cycle still counts as a normal completion.
          if (MemAck || busy_last) begin
            state  <= IDLE;
            MemReq <= 1'b0;
            MemWe  <= 1'b0;
            Err    <= !MemAck;
            if (state == BUSY_I) begin
              InstrDone  <= 1'b1;
              InstrRdata <= MemAck ? MemRdata : '0;
            end else begin
              DataDone  <= 1'b1;
              DataRdata <= (MemAck && !MemWe) ? MemRdata : '0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          MemReq <= 1'b0;
          MemWe  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic, compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int W  = 16;
  localparam int SL = 4;
  localparam int TO = 8;

  logic         Clock;
  logic         Resetn;
  logic         InstrReq, DataReq, DataWe, MemAck;
  logic [W-1:0] InstrAddr, DataAddr, DataWdata, MemRdata;
  logic         InstrGrant, InstrDone, DataGrant, DataDone, MemReq, MemWe, Err;
  logic [W-1:0] InstrRdata, DataRdata, MemAddr, MemWdata;

  mem_arbiter #(.WORD_SIZE(W), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .InstrReq   (InstrReq),
    .InstrAddr  (InstrAddr),
    .InstrGrant (InstrGrant),
    .InstrDone  (InstrDone),
    .InstrRdata (InstrRdata),
    .DataReq    (DataReq),
    .DataWe     (DataWe),
    .DataAddr   (DataAddr),
    .DataWdata  (DataWdata),
    .DataGrant  (DataGrant),
    .DataDone   (DataDone),
    .DataRdata  (DataRdata),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWdata   (MemWdata),
    .MemRdata   (MemRdata),
    .MemAck     (MemAck),
    .Err        (Err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef enum int {REQ_ONESHOT, REQ_HOLD, REQ_RANDOM} req_mode_e;

  // One accepted transaction as the reference model sees it.
  typedef struct {
    bit           valid;
    bit           is_data;
    bit           we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] mdata;
    logic [W-1:0] rdata;
    int           grant_c;
    int           ack_c;
    int           done_c;
    bit           err;
  } txn_t;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           free_at = 0;   // first cycle in which a new grant may issue
  int           starve = 0;
  txn_t         cur;
  req_mode_e    mode = REQ_ONESHOT;
  int           force_delay = -1;
  bit           force_md = 1'b0;
  logic [W-1:0] force_mdata = '0;
  bit           n_ireq = 1'b0, n_dreq = 1'b0, n_dwe = 1'b0;
  logic [W-1:0] n_iaddr = '0, n_daddr = '0, n_dwdata = '0;
  int           obs_grant_c = 0, obs_done_c = 0, obs_memreq = 0, gcount = 0;
  bit           obs_err = 1'b0;
  logic [W-1:0] obs_rdata = '0;
  logic [31:0]  gbits = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".instr_grant"}, InstrGrant, 0);
    check({tag, ".data_grant"},  DataGrant,  0);
    check({tag, ".instr_done"},  InstrDone,  0);
    check({tag, ".data_done"},   DataDone,   0);
    check({tag, ".err"},         Err,        0);
    check({tag, ".mem_req"},     MemReq,     0);
    check({tag, ".mem_we"},      MemWe,      0);
    check({tag, ".mem_addr"},    MemAddr,    0);
    check({tag, ".mem_wdata"},   MemWdata,   0);
    check({tag, ".instr_rdata"}, InstrRdata, 0);
    check({tag, ".data_rdata"},  DataRdata,  0);
  endtask

  // One clock cycle: drive inputs after the rising edge, compare at the falling edge,
  // then advance the reference model.
  task automatic run_cycle();
    bit eig, edg, edone, busy;
    int delay, r;
    @(posedge Clock);
    #1;
    cyc++;
    InstrReq  = n_ireq;
    InstrAddr = n_iaddr;
    DataReq   = n_dreq;
    DataWe    = n_dwe;
    DataAddr  = n_daddr;
    DataWdata = n_dwdata;
    MemRdata  = W'($urandom);
    if (cur.valid && cyc == cur.ack_c) begin
      MemAck   = 1'b1;
      MemRdata = cur.mdata;
    end else begin
      // Stray acks while the arbiter is idle must have no effect.
      MemAck = (cyc >= free_at) && ($urandom_range(0, 7) == 0);
    end
    @(negedge Clock);

    eig = 1'b0;
    edg = 1'b0;
    if (cyc >= free_at) begin
      if (InstrReq && DataReq) begin
        eig = (starve == SL);
        edg = !eig;
      end else begin
        eig = InstrReq;
        edg = DataReq;
      end
    end
    edone = cur.valid && (cyc == cur.done_c);
    busy  = cur.valid && (cyc > cur.grant_c) && (cyc < cur.done_c);

    check("instr_grant", InstrGrant, eig);
    check("data_grant",  DataGrant,  edg);
    check("instr_done",  InstrDone,  edone && !cur.is_data);
    check("data_done",   DataDone,   edone && cur.is_data);
    check("err",         Err,        edone && cur.err);
    check("mem_req",     MemReq,     busy);
    if (edone) begin
      if (cur.is_data) check("data_rdata", DataRdata, cur.rdata);
      else             check("instr_rdata", InstrRdata, cur.rdata);
    end
    if (busy) begin
      check("mem_addr", MemAddr, cur.addr);
      check("mem_we",   MemWe,   cur.we);
      if (cur.is_data) check("mem_wdata", MemWdata, cur.wdata);
    end

    if (InstrGrant || DataGrant) begin
      obs_grant_c = cyc;
      gbits       = {gbits[30:0], InstrGrant};
      gcount++;
    end
    if (InstrDone || DataDone) begin
      obs_done_c = cyc;
      obs_err    = Err;
      obs_rdata  = DataDone ? DataRdata : InstrRdata;
    end
    if (MemReq) obs_memreq++;

    if (!InstrReq || eig)    starve = 0;
    else if (edg && starve < SL) starve++;

    if (eig || edg) begin
      if (force_delay >= 0) begin
        delay = force_delay;
      end else begin
        r = int'($urandom_range(0, 15));
        delay = (r < 12) ? (r % 4) : (r < 14) ? (TO - 1) : (TO + 5);
      end
      cur.valid   = 1'b1;
      cur.is_data = edg;
      cur.we      = edg && DataWe;
      cur.addr    = edg ? DataAddr : InstrAddr;
      cur.wdata   = DataWdata;
      cur.mdata   = force_md ? force_mdata : W'($urandom);
      cur.grant_c = cyc;
      if (delay < TO) begin
        cur.ack_c  = cyc + 1 + delay;
        cur.done_c = cyc + 2 + delay;
        cur.err    = 1'b0;
        cur.rdata  = cur.we ? '0 : cur.mdata;
      end else begin
        cur.ack_c  = -1;
        cur.done_c = cyc + TO + 1;
        cur.err    = 1'b1;
        cur.rdata  = '0;
      end
      free_at = cur.done_c;
    end

    case (mode)
      REQ_ONESHOT: begin
        if (eig) n_ireq = 1'b0;
        if (edg) n_dreq = 1'b0;
      end
      REQ_HOLD: ;
      default: begin
        if (eig || !InstrReq) begin
          n_ireq  = ($urandom_range(0, 2) != 0);
          n_iaddr = W'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          n_ireq = 1'b0;
        end
        if (edg || !DataReq) begin
          n_dreq   = ($urandom_range(0, 2) != 0);
          n_dwe    = 1'($urandom_range(0, 1));
          n_daddr  = W'($urandom);
          n_dwdata = W'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          n_dreq = 1'b0;
        end
      end
    endcase
  endtask

  task automatic run_until_idle(input string tag);
    int n = 0;
    while ((cyc < free_at || n_ireq || n_dreq) && n < 200) begin
      run_cycle();
      n++;
    end
    check({tag, ".drain_in_budget"}, (n < 200), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=still running expected=finished");
    $fatal(1);
  end

  initial begin
    int n;
    cur = '{default: 0};
    Resetn    = 1'b0;
    InstrReq  = 1'b1;
    DataReq   = 1'b1;
    DataWe    = 1'b1;
    InstrAddr = '1;
    DataAddr  = '1;
    DataWdata = '1;
    MemAck    = 1'b1;
    MemRdata  = '1;
    repeat (3) @(negedge Clock);
    check_outputs_zero("reset");
    InstrReq = 1'b0;
    DataReq  = 1'b0;
    DataWe   = 1'b0;
    MemAck   = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;

    // Single fetch with zero-wait memory.
    n_ireq = 1'b1; n_iaddr = 16'h0010;
    force_delay = 0; force_md = 1'b1; force_mdata = 16'hBEEF;
    run_until_idle("fetch");
    check("fetch.latency", obs_done_c - obs_grant_c, 2);
    check("fetch.rdata", obs_rdata, 16'hBEEF);
    check("fetch.err", obs_err, 0);

    // Both requesters held: fetch wins once every STARVE_LIMIT data grants.
    mode = REQ_HOLD; force_md = 1'b0; gcount = 0; gbits = '0;
    n_ireq = 1'b1; n_iaddr = 16'h0040;
    n_dreq = 1'b1; n_dwe = 1'b0; n_daddr = 16'h0080;
    n = 0;
    while (gcount < 10 && n < 100) begin
      run_cycle();
      n++;
    end
    check("contention.grants_seen", gcount, 10);
    check("contention.order", gbits[9:0], 10'b0000100001);
    n_ireq = 1'b0; n_dreq = 1'b0; mode = REQ_ONESHOT;
    run_until_idle("contention");

    // Write with three busy cycles.
    n_dreq = 1'b1; n_dwe = 1'b1; n_daddr = 16'h0100; n_dwdata = 16'h1234;
    force_delay = 2; obs_memreq = 0;
    run_until_idle("write");
    check("write.memreq_cycles", obs_memreq, 3);
    check("write.latency", obs_done_c - obs_grant_c, 4);
    check("write.rdata", obs_rdata, 0);
    check("write.err", obs_err, 0);

    // No ack at all: abort after TIMEOUT busy cycles.
    n_dreq = 1'b1; n_dwe = 1'b0; n_daddr = 16'h0200;
    force_delay = 100; obs_memreq = 0;
    run_until_idle("timeout");
    check("timeout.memreq_cycles", obs_memreq, TO);
    check("timeout.latency", obs_done_c - obs_grant_c, TO + 1);
    check("timeout.err", obs_err, 1);
    check("timeout.rdata", obs_rdata, 0);

    // Ack in the last allowed busy cycle completes normally.
    n_dreq = 1'b1; n_dwe = 1'b0; n_daddr = 16'h0204;
    force_delay = TO - 1; force_md = 1'b1; force_mdata = 16'hCAFE; obs_memreq = 0;
    run_until_idle("ack_at_timeout");
    check("ack_at_timeout.memreq_cycles", obs_memreq, TO);
    check("ack_at_timeout.err", obs_err, 0);
    check("ack_at_timeout.rdata", obs_rdata, 16'hCAFE);

    // Randomized traffic against the reference model.
    force_delay = -1; force_md = 1'b0; mode = REQ_RANDOM;
    repeat (1500) run_cycle();
    mode = REQ_ONESHOT; n_ireq = 1'b0; n_dreq = 1'b0;
    run_until_idle("random");

    // Reset while a data write is in flight, then a late ack.
    n_dreq = 1'b1; n_dwe = 1'b1; n_daddr = 16'h0300; n_dwdata = 16'h5A5A;
    force_delay = 100;
    run_cycle();
    run_cycle();
    #2 Resetn = 1'b0;
    #1 check_outputs_zero("reset_busy");
    @(negedge Clock);
    Resetn = 1'b1;
    cur.valid = 1'b0; free_at = 0; starve = 0;
    repeat (4) begin
      @(posedge Clock);
      #1;
      MemAck   = 1'b1;
      MemRdata = 16'hFFFF;
      @(negedge Clock);
      check_outputs_zero("late_ack");
    end
    MemAck = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
